// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the IF-stage program-counter / fetch-request generator:
// FSM state encodings, pipeline stall polarity constants and the default reset vector.
package pc_fetch_gen_pkg;

    typedef enum logic [1:0] {
        PCF_OFF   = 2'd0,
        PCF_FETCH = 2'd1,
        PCF_STALL = 2'd2
    } pcf_state_e;

    localparam logic NOSTOP = 1'b0;
    localparam logic STOP   = 1'b1;

    localparam logic [31:0] PCF_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: remembers a taken branch target that arrived while
// the fetch could not advance, until the next advance consumes it or a flush drops it.
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              consume_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Clear and consume both drop the entry; a newer branch overwrites an older one.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (clr_i || consume_i) begin
            vld_d = 1'b0;
        end else if (wr_i) begin
            vld_d  = 1'b1;
            addr_d = wr_addr_i;
        end
    end

    // Valid flag is control state and is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stored target is only meaningful while valid, so it is left unreset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/pc_fetch_gen.sv
// IF-stage program counter and instruction-fetch request generator.
// Optional build macro PC_ALIGN_CHK_EN: flags a PC that is not STEP-aligned
// (misalign, used as AdEL) and suppresses the fetch request while it is set.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = PCF_RESET_VEC,
    parameter int unsigned STEP      = 4,
    parameter int          STALL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               inst_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               inst_req,
    output logic [ADDR_W-1:0]  inst_addr,
    output logic               inst_valid,
    output logic               misalign
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

    pcf_state_e        state_q, state_d;
    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              stall_pc;
    logic              req;
    logic              adv;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic              misalign_w;
    logic              unused_stall;

    // Only the PC-stage bit of the stall vector matters here.
    assign stall_pc     = (stall[0] == STOP);
    assign unused_stall = ^stall;

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    // Alignment flag tracks the PC it describes, so it is computed from pc_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (pc_d % ADDR_W'(STEP)) != '0;
        end
    end

    assign misalign_w = misalign_q;
`else
    assign misalign_w = 1'b0;
`endif

    // Request and advance qualifiers: a captured word waiting out a stall advances without a new ack.
    always_comb begin
        req = (state_q == PCF_FETCH) && !misalign_w;
        adv = ((req && inst_ack) || (state_q == PCF_STALL)) && !stall_pc;
    end

    // Next state and next PC; flush beats branch, branch beats pending redirect, which beats sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            PCF_OFF:   state_d = PCF_FETCH;
            PCF_FETCH: if (req && inst_ack && stall_pc) state_d = PCF_STALL;
            PCF_STALL: if (!stall_pc) state_d = PCF_FETCH;
            default:   state_d = PCF_OFF;
        endcase
        if (ce_q) begin
            if (flush) begin
                pc_d    = new_pc;
                state_d = PCF_FETCH;
            end else if (adv && branch_flag_i) begin
                pc_d = branch_target_address_i;
            end else if (adv && pend_vld) begin
                pc_d = pend_addr;
            end else if (adv) begin
                pc_d = pc_q + ADDR_W'(STEP);
            end
        end
    end

    // State, enable and PC registers; ce rises on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PCF_OFF;
            ce_q    <= 1'b0;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            ce_q    <= 1'b1;
            pc_q    <= pc_d;
        end
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ce_q && flush),
        .wr_i      (ce_q && !flush && !adv && branch_flag_i),
        .wr_addr_i (branch_target_address_i),
        .consume_i (adv),
        .vld_o     (pend_vld),
        .addr_o    (pend_addr)
    );

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign inst_req   = req;
    assign inst_addr  = pc_q;
    assign inst_valid = adv && !flush;
    assign misalign   = misalign_w;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed stimulus with literal expectations
// plus a cycle-level behavioural model compared on every falling edge.
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        inst_ack;
    logic [31:0] pc;
    logic        ce;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        misalign;

    logic [15:0] pc16, inst_addr16;
    logic        ce16, inst_req16, inst_valid16, misalign16;

    int checks = 0;
    int errors = 0;

    pc_fetch_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000),
        .STEP      (4),
        .STALL_W   (6)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_ack                (inst_ack),
        .pc                      (pc),
        .ce                      (ce),
        .inst_req                (inst_req),
        .inst_addr               (inst_addr),
        .inst_valid              (inst_valid),
        .misalign                (misalign)
    );

    // 16-bit instance: reset vector 0x1FFFC truncates to 0xFFFC, then wraps to 0.
    pc_fetch_gen #(
        .ADDR_W    (16),
        .RESET_VEC (32'h0001_FFFC),
        .STEP      (4),
        .STALL_W   (6)
    ) dut16 (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (6'd0),
        .flush                   (1'b0),
        .new_pc                  (16'd0),
        .branch_flag_i           (1'b0),
        .branch_target_address_i (16'd0),
        .inst_ack                (1'b1),
        .pc                      (pc16),
        .ce                      (ce16),
        .inst_req                (inst_req16),
        .inst_addr               (inst_addr16),
        .inst_valid              (inst_valid16),
        .misalign                (misalign16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_ce = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_held = 1'b0;      // word captured during stall, waiting to be accepted
    logic        m_pend = 1'b0;
    logic [31:0] m_paddr = 32'h0;
    logic        m_mis = 1'b0;
    logic        u_req, u_adv, u_cap;

    always @(posedge clk) begin
        u_req = m_ce && !m_held && !m_mis;
        u_adv = m_ce && !stall[0] && (m_held || (u_req && inst_ack));
        u_cap = u_req && inst_ack && stall[0];
        if (rst) begin
            m_ce = 0; m_pc = 32'h0; m_held = 0; m_pend = 0; m_mis = 0;
        end else begin
            if (!m_ce) begin
                m_ce = 1;
            end else if (flush) begin
                m_pc = new_pc; m_pend = 0; m_held = 0;
            end else if (u_adv) begin
                if (branch_flag_i)  m_pc = branch_target_address_i;
                else if (m_pend)    m_pc = m_paddr;
                else                m_pc = m_pc + 32'd4;
                m_pend = 0; m_held = 0;
            end else begin
                if (u_cap) m_held = 1;
                if (branch_flag_i) begin
                    m_pend = 1; m_paddr = branch_target_address_i;
                end
            end
`ifdef PC_ALIGN_CHK_EN
            m_mis = (m_pc % 32'd4) != 0;
`else
            m_mis = 0;
`endif
        end
    end

    logic e_req, e_adv;
    always @(negedge clk) begin
        e_req = m_ce && !m_held && !m_mis;
        e_adv = m_ce && !stall[0] && (m_held || (e_req && inst_ack));
        chk("model_pc", pc, m_pc);
        chk("model_inst_addr", inst_addr, m_pc);
        chk("model_ce", {31'd0, ce}, {31'd0, m_ce});
        chk("model_inst_req", {31'd0, inst_req}, {31'd0, e_req});
        chk("model_inst_valid", {31'd0, inst_valid}, {31'd0, e_adv && !flush});
        chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ack, input logic st, input logic br, input logic [31:0] tgt,
                       input logic fl, input logic [31:0] npc);
        inst_ack = ack;
        stall = {5'd0, st};
        branch_flag_i = br;
        branch_target_address_i = tgt;
        flush = fl;
        new_pc = npc;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        drv(1, 0, 0, 0, 0, 0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc16_trunc", {16'd0, pc16}, 32'h0000_FFFC);

        // Sequential fetch out of reset.
        rst = 1'b0;
        tick;
        chk("t1_pc0", pc, 32'h0);
        chk("t1_ce", {31'd0, ce}, 32'd1);
        chk("t1_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_pc16", {16'd0, pc16}, 32'h0000_FFFC);
        tick;
        chk("t1_pc4", pc, 32'h4);
        chk("t5_pc16_wrap", {16'd0, pc16}, 32'h0);
        tick;
        chk("t1_pc8", pc, 32'h8);

        // Branch arriving during memory wait is held and consumed on the ack.
        drv(0, 0, 1, 32'h100, 0, 0);
        tick;
        chk("t2_hold1", pc, 32'h8);
        drv(0, 0, 0, 0, 0, 0);
        tick;
        chk("t2_hold2", pc, 32'h8);
        tick;
        chk("t2_hold3", pc, 32'h8);
        drv(1, 0, 0, 0, 0, 0);
        chk("t2_valid", {31'd0, inst_valid}, 32'd1);
        tick;
        chk("t2_pend_pc", pc, 32'h100);

        drv(1, 0, 1, 32'h10, 0, 0);
        tick;
        chk("t3_at10", pc, 32'h10);

        // Ack during stall: word captured, no refetch, single valid pulse on release.
        drv(1, 1, 0, 0, 0, 0);
        chk("t3_no_valid_ack_stall", {31'd0, inst_valid}, 32'd0);
        tick;
        chk("t3_stall_pc", pc, 32'h10);
        chk("t3_stall_req", {31'd0, inst_req}, 32'd0);
        drv(0, 1, 0, 0, 0, 0);
        chk("t3_stall_valid0", {31'd0, inst_valid}, 32'd0);
        tick;
        chk("t3_stall_pc2", pc, 32'h10);
        drv(0, 0, 0, 0, 0, 0);
        chk("t3_release_valid", {31'd0, inst_valid}, 32'd1);
        tick;
        chk("t3_pc14", pc, 32'h14);
        chk("t3_valid_once", {31'd0, inst_valid}, 32'd0);
        chk("t3_req_back", {31'd0, inst_req}, 32'd1);

        // Flush beats ack, branch and pending redirect.
        drv(0, 0, 1, 32'h300, 0, 0);
        tick;
        chk("t4_pend_hold", pc, 32'h14);
        drv(1, 0, 1, 32'h200, 1, 32'h180);
        chk("t4_flush_valid", {31'd0, inst_valid}, 32'd0);
        tick;
        chk("t4_flush_pc", pc, 32'h180);
        drv(1, 0, 0, 0, 0, 0);
        tick;
        chk("t4_pend_cleared", pc, 32'h184);

        // Full-width wrap.
        drv(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        tick;
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        drv(1, 0, 0, 0, 0, 0);
        tick;
        chk("wrap_zero", pc, 32'h0);

        // Reset mid-operation drops a pending redirect.
        drv(0, 0, 1, 32'h500, 0, 0);
        tick;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        tick;
        chk("mrst_ce", {31'd0, ce}, 32'd0);
        chk("mrst_pc", pc, 32'h0);
        rst = 1'b0;
        tick;
        drv(1, 0, 0, 0, 0, 0);
        tick;
        chk("mrst_no_pend", pc, 32'h4);

        // Misaligned branch target.
        drv(1, 0, 1, 32'h102, 0, 0);
        tick;
        chk("t6_pc102", pc, 32'h102);
`ifdef PC_ALIGN_CHK_EN
        chk("t6_misalign", {31'd0, misalign}, 32'd1);
        chk("t6_req_gated", {31'd0, inst_req}, 32'd0);
        drv(1, 0, 0, 0, 0, 0);
        tick;
        chk("t6_pc_held", pc, 32'h102);
        drv(0, 0, 0, 0, 1, 32'h180);
        tick;
        chk("t6_flush_pc", pc, 32'h180);
        chk("t6_misalign_clr", {31'd0, misalign}, 32'd0);
        chk("t6_req_restored", {31'd0, inst_req}, 32'd1);
`else
        chk("t6_misalign_tied", {31'd0, misalign}, 32'd0);
        chk("t6_req_ungated", {31'd0, inst_req}, 32'd1);
        drv(1, 0, 0, 0, 0, 0);
        tick;
        chk("t6_pc106", pc, 32'h106);
`endif

        drv(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
